// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: load-use and multiplier stalls, redirect flush, dmem freeze.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_unit #(
  parameter  int unsigned REG_AW    = 5,
  parameter  int unsigned FWD_DEPTH = 2,
  parameter  int unsigned MUL_LAT   = 4,
  localparam int unsigned FW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_m2reg,
  input  logic              id_mul,
  input  logic              id_redirect,
  input  logic              mem_ready,
  output logic [FW-1:0]     fwda,
  output logic [FW-1:0]     fwdb,
  output logic              wpcir,
  output logic              bubble,
  output logic              flush,
  output logic              freeze,
  output logic              mul_busy,
  output logic              mul_done,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_lu,
  output logic [31:0]       perf_mul,
  output logic [31:0]       perf_flush,
`endif
  output logic [REG_AW-1:0] mul_rn
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  logic              r_vld [1:FWD_DEPTH];
  logic [REG_AW-1:0] r_rn  [1:FWD_DEPTH];
  logic              r_ld  [1:FWD_DEPTH];
  logic              r_flush;
  logic [CW-1:0]     r_mul_cnt;
  logic [REG_AW-1:0] r_mul_rn;

  logic [FWD_DEPTH:1] w_hit_a, w_hit_b, w_src_a, w_src_b;
  logic [FW-1:0]      w_fwda, w_fwdb;
  logic               w_id_valid, w_freeze, w_lu_stall, w_mul_pend, w_mul_hit;
  logic               w_mul_stall, w_stall, w_wpcir, w_issue, w_rec1_ld;

  // Per-stage hazard hits; a stage-1 load has no data yet, so it is not a forwarding source.
  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    w_src_a = '0;
    w_src_b = '0;
    for (int s = 1; s <= int'(FWD_DEPTH); s++) begin
      w_hit_a[s] = r_vld[s] && (r_rn[s] != '0) && (r_rn[s] == id_rs) && id_use_rs;
      w_hit_b[s] = r_vld[s] && (r_rn[s] != '0) && (r_rn[s] == id_rt) && id_use_rt;
      w_src_a[s] = w_hit_a[s] && !((s == 1) && r_ld[s]);
      w_src_b[s] = w_hit_b[s] && !((s == 1) && r_ld[s]);
    end
  end

  // Youngest producer wins: scan oldest to youngest so the lowest stage overrides.
  always_comb begin
    w_fwda = '0;
    w_fwdb = '0;
    for (int s = int'(FWD_DEPTH); s >= 1; s--) begin
      if (w_src_a[s]) w_fwda = FW'(s);
      if (w_src_b[s]) w_fwdb = FW'(s);
    end
  end

  assign w_id_valid = ~r_flush;
  assign w_freeze   = r_vld[2] & r_ld[2] & ~mem_ready;
  assign w_lu_stall = w_id_valid & r_vld[1] & r_ld[1] & (w_hit_a[1] | w_hit_b[1]);

  // The result is written in the done cycle (count 1), so only counts above 1 block ID.
  assign w_mul_pend = (r_mul_cnt > CW'(1));
  assign w_mul_hit  = (r_mul_rn != '0) &&
                      ((id_use_rs && (id_rs == r_mul_rn)) ||
                       (id_use_rt && (id_rt == r_mul_rn)) ||
                       (id_wreg   && (id_rn == r_mul_rn)));
  assign w_mul_stall = w_id_valid & w_mul_pend & (w_mul_hit | id_mul);

  assign w_stall   = w_lu_stall | w_mul_stall;
  assign w_wpcir   = ~w_freeze & ~w_stall;
  assign w_issue   = w_wpcir & w_id_valid & id_mul;
  assign w_rec1_ld = w_wpcir & w_id_valid & id_wreg & ~id_mul;

  assign fwda     = w_fwda;
  assign fwdb     = w_fwdb;
  assign wpcir    = w_wpcir;
  assign bubble   = ~w_freeze & w_stall;
  assign flush    = r_flush;
  assign freeze   = w_freeze;
  assign mul_busy = (r_mul_cnt != '0);
  assign mul_done = (r_mul_cnt == CW'(1)) & ~w_freeze;
  assign mul_rn   = r_mul_rn;

  // In-flight destination records shift one stage per unfrozen edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int s = 1; s <= int'(FWD_DEPTH); s++) begin
        r_vld[s] <= 1'b0;
        r_rn[s]  <= '0;
        r_ld[s]  <= 1'b0;
      end
    end else if (!w_freeze) begin
      r_vld[1] <= w_rec1_ld;
      r_rn[1]  <= id_rn;
      r_ld[1]  <= id_m2reg;
      for (int s = 2; s <= int'(FWD_DEPTH); s++) begin
        r_vld[s] <= r_vld[s-1];
        r_rn[s]  <= r_rn[s-1];
        r_ld[s]  <= r_ld[s-1];
      end
    end
  end

  // Multiplier scoreboard and flush register; an issue at count 1 reloads with no dead cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_flush   <= 1'b0;
      r_mul_cnt <= '0;
      r_mul_rn  <= '0;
    end else if (!w_freeze) begin
      r_flush <= id_redirect & w_wpcir & ~r_flush;
      if (w_issue) begin
        r_mul_cnt <= CW'(MUL_LAT);
        r_mul_rn  <= id_rn;
      end else if (r_mul_cnt != '0) begin
        r_mul_cnt <= r_mul_cnt - CW'(1);
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_lu, r_perf_mul, r_perf_flush;

  // Saturating event counters, sampled only on unfrozen cycles.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_perf_lu    <= '0;
      r_perf_mul   <= '0;
      r_perf_flush <= '0;
    end else if (!w_freeze) begin
      if (w_lu_stall && (r_perf_lu != '1))   r_perf_lu    <= r_perf_lu + 32'd1;
      if (w_mul_stall && (r_perf_mul != '1)) r_perf_mul   <= r_perf_mul + 32'd1;
      if (r_flush && (r_perf_flush != '1))   r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_lu    = r_perf_lu;
  assign perf_mul   = r_perf_mul;
  assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: cycle table of {ID inputs, expected outputs}
// run through a scoreboard queue, plus a hand-written async-reset-mid-multiply sequence.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt, wreg;
    logic [4:0] rn;
    logic       m2, mul, red, mrdy;
    logic [1:0] fa, fb;
    logic       wp, bub, fl, fr, busy, done;
    logic [4:0] mrn;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_mul, id_redirect, mem_ready;
  logic [1:0] fwda, fwdb;
  logic       wpcir, bubble, flush, freeze, mul_busy, mul_done;
  logic [4:0] mul_rn;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_mul, perf_flush;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t  tbl[$];
  string tnm[$];
  vec_t  exp_q[$];
  string exp_nm[$];

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn), .id_m2reg(id_m2reg), .id_mul(id_mul),
    .id_redirect(id_redirect), .mem_ready(mem_ready),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble), .flush(flush),
    .freeze(freeze), .mul_busy(mul_busy), .mul_done(mul_done),
`ifdef HAZARD_PERF_EN
    .perf_lu(perf_lu), .perf_mul(perf_mul), .perf_flush(perf_flush),
`endif
    .mul_rn(mul_rn)
  );

  task automatic add(input string nm,
                     input int rs, input int rt, input int urs, input int urt,
                     input int wreg, input int rn, input int m2, input int mul,
                     input int red, input int mrdy,
                     input int fa, input int fb, input int wp, input int bub,
                     input int fl, input int fr, input int busy, input int done,
                     input int mrn);
    vec_t v;
    v.rs = 5'(rs);   v.rt = 5'(rt);   v.urs = 1'(urs); v.urt = 1'(urt);
    v.wreg = 1'(wreg); v.rn = 5'(rn); v.m2 = 1'(m2);   v.mul = 1'(mul);
    v.red = 1'(red); v.mrdy = 1'(mrdy);
    v.fa = 2'(fa);   v.fb = 2'(fb);   v.wp = 1'(wp);   v.bub = 1'(bub);
    v.fl = 1'(fl);   v.fr = 1'(fr);   v.busy = 1'(busy); v.done = 1'(done);
    v.mrn = 5'(mrn);
    tbl.push_back(v);
    tnm.push_back(nm);
  endtask

  // Idle ID slot (no reads, no writes) with given mem_ready and expected status outputs.
  task automatic nop(input string nm, input int mrdy, input int fa, input int wp,
                     input int fl, input int busy, input int done, input int mrn);
    add(nm, 0,0,0,0, 0,0,0,0, 0,mrdy, fa,0,wp,0, fl,0,busy,done, mrn);
  endtask

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s %s got=%0d exp=%0d", nm, f, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
    id_wreg = v.wreg; id_rn = v.rn; id_m2reg = v.m2; id_mul = v.mul;
    id_redirect = v.red; mem_ready = v.mrdy;
  endtask

  task automatic compare_front();
    vec_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard underflow");
    end else begin
      e  = exp_q.pop_front();
      nm = exp_nm.pop_front();
      chk(nm, "fwda", 32'(fwda), 32'(e.fa));
      chk(nm, "fwdb", 32'(fwdb), 32'(e.fb));
      chk(nm, "wpcir", 32'(wpcir), 32'(e.wp));
      chk(nm, "bubble", 32'(bubble), 32'(e.bub));
      chk(nm, "flush", 32'(flush), 32'(e.fl));
      chk(nm, "freeze", 32'(freeze), 32'(e.fr));
      chk(nm, "mul_busy", 32'(mul_busy), 32'(e.busy));
      chk(nm, "mul_done", 32'(mul_done), 32'(e.done));
      chk(nm, "mul_rn", 32'(mul_rn), 32'(e.mrn));
    end
  endtask

  // One pipeline cycle: drive after the edge, compare at the falling edge.
  task automatic step(input vec_t v, input string nm);
    drive(v);
    exp_q.push_back(v);
    exp_nm.push_back(nm);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input vec_t v, input string nm);
    drive(v);
    exp_q.push_back(v);
    exp_nm.push_back(nm);
    #1;
    compare_front();
  endtask

  initial begin
    vec_t idle;
    // load-use stall, then forwarding from M and E
    add("lu_issue", 1,0,1,0, 1,3,1,0, 0,1, 0,0,1,0, 0,0,0,0, 0);
    add("lu_stall", 3,2,1,1, 1,4,0,0, 0,1, 0,0,0,1, 0,0,0,0, 0);
    add("lu_fwd_m", 3,2,1,1, 1,4,0,0, 0,1, 2,0,1,0, 0,0,0,0, 0);
    add("fwd_e",    4,4,1,1, 0,0,0,0, 0,1, 1,1,1,0, 0,0,0,0, 0);
    add("fwd_m",    4,0,1,0, 0,0,0,0, 0,1, 2,0,1,0, 0,0,0,0, 0);
    // youngest producer wins; r0 never forwards
    add("add5_a",   0,0,0,0, 1,5,0,0, 0,1, 0,0,1,0, 0,0,0,0, 0);
    add("add5_b",   0,0,0,0, 1,5,0,0, 0,1, 0,0,1,0, 0,0,0,0, 0);
    add("young",    5,5,0,1, 0,0,0,0, 0,1, 0,1,1,0, 0,0,0,0, 0);
    add("old",      5,5,0,1, 0,0,0,0, 0,1, 0,2,1,0, 0,0,0,0, 0);
    add("add0",     0,0,0,0, 1,0,0,0, 0,1, 0,0,1,0, 0,0,0,0, 0);
    add("rn0",      0,0,1,1, 0,0,0,0, 0,1, 0,0,1,0, 0,0,0,0, 0);
    nop("idle_b", 1, 0,1,0, 0,0, 0);
    // freeze holds records and multiplier count, overrides a mul stall
    add("mul11",    0,0,0,0, 1,11,0,1, 0,1, 0,0,1,0, 0,0,0,0, 0);
    add("lw12",     0,0,0,0, 1,12,1,0, 0,1, 0,0,1,0, 0,0,1,0, 11);
    nop("mrdy0_e", 0, 0,1,0, 1,0, 11);
    for (int i = 0; i < 3; i++)
      add("frz",   12,0,1,0, 1,13,0,1, 0,0, 2,0,0,0, 0,1,1,0, 11);
    nop("unfrz",  1, 0,1,0, 1,0, 11);
    nop("mdone_f",1, 0,1,0, 1,1, 11);
    nop("midle_f",1, 0,1,0, 0,0, 11);
    // flushed slot: no load-use stall; consecutive redirects flush once
    add("redir",    0,0,0,0, 1,6,1,0, 1,1, 0,0,1,0, 0,0,0,0, 11);
    add("flushed",  6,0,1,0, 1,9,0,0, 1,1, 0,0,1,0, 1,0,0,0, 11);
    nop("post_fl1", 1, 0,1,0, 0,0, 11);
    nop("post_fl2", 1, 0,1,0, 0,0, 11);
    // redirect during a stall is taken once the stall clears
    add("lw3",      0,0,0,0, 1,3,1,0, 0,1, 0,0,1,0, 0,0,0,0, 11);
    add("stl_red",  3,0,1,0, 1,4,0,0, 1,1, 0,0,0,1, 0,0,0,0, 11);
    add("red_go",   3,0,1,0, 1,4,0,0, 1,1, 2,0,1,0, 0,0,0,0, 11);
    nop("late_fl",  1, 0,1,1, 0,0, 11);
    nop("late_fl0", 1, 0,1,0, 0,0, 11);
    // MUL_LAT=4: dependent read stalls 3 cycles, issues in the done cycle
    add("mul7",     0,0,0,0, 1,7,0,1, 0,1, 0,0,1,0, 0,0,0,0, 11);
    for (int i = 0; i < 3; i++)
      add("mul_dep",7,0,1,0, 1,8,0,0, 0,1, 0,0,0,1, 0,0,1,0, 7);
    add("dep_go",   7,0,1,0, 1,8,0,0, 0,1, 0,0,1,0, 0,0,1,1, 7);
    nop("mul7_end", 1, 0,1,0, 0,0, 7);
    // back-to-back multiplies: second reissues at count 1
    add("mul9",     0,0,0,0, 1,9,0,1, 0,1, 0,0,1,0, 0,0,0,0, 7);
    for (int i = 0; i < 3; i++)
      add("mul_mul",0,0,0,0, 1,10,0,1, 0,1, 0,0,0,1, 0,0,1,0, 9);
    add("mul10",    0,0,0,0, 1,10,0,1, 0,1, 0,0,1,0, 0,0,1,1, 9);
    nop("m10_c4",   1, 0,1,0, 1,0, 10);
    nop("m10_c3",   1, 0,1,0, 1,0, 10);

    idle = '0;
    idle.mrdy = 1'b1;
    idle.wp   = 1'b1;

    clrn = 1'b0;
    drive(idle);
    #2;
    check_now(idle, "reset");
    @(posedge clk);
    #1;
    clrn = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], tnm[i]);

    // Reset asserted mid-multiply (count 2): outputs return immediately, no late done.
    begin
      vec_t pre;
      pre = idle;
      pre.busy = 1'b1;
      pre.mrn  = 5'd10;
      check_now(pre, "pre_rst");
      clrn = 1'b0;
      check_now(idle, "rst_async");
      @(posedge clk);
      #1;
      clrn = 1'b1;
      for (int i = 0; i < 5; i++)
        step(idle, "post_rst");
    end

    chk("end", "queue_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined CPU.
- Successor to the fixed two-stage forwarding/stall logic in the control unit.
- Tracks in-flight destination registers across FWD_DEPTH downstream stages and produces forwarding selects, load-use stalls and redirect flushes.
- Adds a multi-cycle multiplier scoreboard and a data-memory wait freeze; sits beside the ID-stage decoder.

Parameters:
- REG_AW, 5, register-number width; register 0 is never a hazard source.
- FWD_DEPTH, 2, tracked stages after ID (1=E, 2=M, ...); minimum 2.
- MUL_LAT, 4, multiplier latency in non-frozen cycles; minimum 1.
- FW, $clog2(FWD_DEPTH+1), forwarding-select width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes a register.
- id_rn  in  REG_AW  destination register.
- id_m2reg  in  1  instruction is a load.
- id_mul  in  1  instruction is a multiply (result via multiplier, not pipe).
- id_redirect  in  1  branch taken / jump resolved in ID.
- mem_ready  in  1  data memory done this cycle.
- fwda  out  FW  rs source: 0=regfile, s=stage s result.
- fwdb  out  FW  rt source, same encoding.
- wpcir  out  1  PC/IR write enable.
- bubble  out  1  insert NOP into E this cycle.
- flush  out  1  kill instruction currently in ID.
- freeze  out  1  whole pipe holds.
- mul_busy  out  1  multiplier counter nonzero.
- mul_done  out  1  one-cycle pulse, multiplier writes mul_rn.
- mul_rn  out  REG_AW  multiplier destination.

Behaviour:
- Reset (clrn=0, async): all stage records invalid, mul counter 0, mul_rn 0, flush reg 0. Outputs: fwda=fwdb=0, wpcir=1, bubble=0, flush=0, freeze=0, mul_busy=0, mul_done=0.
- Stage record = {valid, rn, load}. Each edge where freeze=0, record s shifts to s+1 and the last record retires (regfile write-through, no forwarding needed).
- Record 1 is loaded from ID when wpcir=1, flush=0, id_wreg=1 and id_mul=0. Otherwise record 1 becomes invalid (bubble).
- A valid ID instruction is one with flush=0.
- Hazard hit on stage s: record valid, rn!=0, rn equals the source, and the matching use_* is set.
- fwda/fwdb select the lowest s with a hit; youngest producer wins. The select is still driven during a stall.
- Load-use stall: a stage-1 hit with load=1 gives wpcir=0 and bubble=1. A load at s>=2 forwards normally.
- Mul stall: valid ID instruction and mul_busy, with either a source or id_rn equal to a nonzero mul_rn, or id_mul=1. Gives wpcir=0 and bubble=1.
- Mul issue: id_mul with no stall loads counter=MUL_LAT and mul_rn=id_rn.
  - Counter decrements on every non-frozen cycle.
  - mul_done=1 in the cycle the counter equals 1.
  - Counter hits 0 on the following edge; there is no dead cycle before the next issue.
- Freeze: freeze = record 2 valid & load & ~mem_ready.
  - Freeze forces wpcir=0 and bubble=0.
  - Records, counter and flush reg all hold.
  - Freeze has priority over stalls.
- Flush: flush reg <= id_redirect & wpcir & ~flush & ~freeze.
  - The flushed ID instruction causes no stall, no record and no mul issue.
  - A redirect in a flushed slot is ignored.
  - A redirect during a stall is re-evaluated when the stall clears.
- Reset mid-multiply: counter is cleared and no mul_done is produced.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds three 32-bit saturating counters and outputs.
  - perf_lu (load-use stall cycles), perf_mul (mul stall cycles), perf_flush (flushes).
  - Counters are cleared by clrn and increment only while not frozen.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw r3 at E; ID uses rs=r3 → wpcir=0, bubble=1, fwda=0. Next cycle: record at M, fwda=2, wpcir=1.
- add r5 at E and add r5 at M; ID reads rt=r5 → fwdb=1 (youngest wins). With rn=0 instead → fwdb=0.
- MUL_LAT=4: mul r7 issued, dependent read of r7 next cycle → stalls 3 cycles. mul_done on the 4th cycle after issue; the dependent instruction issues on the edge that clears the counter.
- lw at M with mem_ready=0 for 3 cycles → freeze=1, wpcir=0, bubble=0 for 3 cycles; records and mul counter unchanged.
- id_redirect=1 with no stall → flush=1 next cycle. A load-use hazard in the flushed slot gives no stall; two consecutive redirects give exactly one flush.
- clrn low while mul counter=2 → mul_busy=0 and all outputs at reset values immediately; no mul_done after release.
